// File: rtl/fb_arb_pkg.sv
// Shared definitions for the framebuffer write-port arbiter: FSM state
// encodings, requester indices and default widths of the paint datapath.
package fb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        RELEASE = 2'b11
    } arb_state_t;

    localparam int REQ_CLEAR  = 0;
    localparam int REQ_BRUSH  = 1;
    localparam int REQ_CURSOR = 2;

    localparam int DEF_N_REQ     = 3;
    localparam int DEF_ADDR_W    = 11;
    localparam int DEF_DATA_W    = 24;
    localparam int DEF_MAX_BURST = 16;

endpackage

// File: rtl/fb_write_arbiter_rr_pick.sv
// Combinational round-robin priority encoder. Scans the request vector
// starting one position after the previous owner and wraps modulo N_REQ,
// so the previous owner is considered last.
module rr_pick #(
    parameter int N_REQ = 3,
    localparam int IW = $clog2(N_REQ)
)(
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic             valid,
    output logic [IW-1:0]    pick
);

    // Walk offsets from farthest to nearest so the nearest requester wins
    always_comb begin
        valid = 1'b0;
        pick  = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            automatic int idx;
            idx = (int'(last) + off) % N_REQ;
            if (req[idx]) begin
                valid = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the single framebuffer write port among the paint requesters
// (clear engine, brush, cursor overlay). Round-robin arbitration with
// burst tenure: the owner keeps the port while it requests, but after
// MAX_BURST granted cycles it is preempted if anyone else is waiting.
// A dead RELEASE cycle separates tenures for bus turnaround.
// All state changes on the falling clock edge.
module fb_write_arbiter
    import fb_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           we_i,
    input  logic [N_REQ*ADDR_W-1:0]    addr_i,
    input  logic [N_REQ*DATA_W-1:0]    data_i,
    output logic [N_REQ-1:0]           gnt,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic                       busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST);
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);
    localparam logic [IW-1:0] LAST_RESET = IW'(N_REQ - 1);

    arb_state_t       state;
    arb_state_t       state_n;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    owner_n;
    logic [IW-1:0]    last;
    logic [IW-1:0]    last_n;
    logic [CW-1:0]    burst_cnt;
    logic [CW-1:0]    burst_cnt_n;
    logic [N_REQ-1:0] gnt_n;
    logic [N_REQ-1:0] owner_oh;
    logic             pick_valid;
    logic [IW-1:0]    pick;

    rr_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .req   (req),
        .last  (last),
        .valid (pick_valid),
        .pick  (pick)
    );

    // State, tenure bookkeeping and the registered grant, on the falling edge
    always_ff @(negedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            last      <= LAST_RESET;
            burst_cnt <= '0;
            gnt       <= '0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            last      <= last_n;
            burst_cnt <= burst_cnt_n;
            gnt       <= gnt_n;
        end
    end

    // Next-state logic: arbitrate in IDLE, count tenure in GRANT, turn around in RELEASE
    always_comb begin
        state_n     = state;
        owner_n     = owner;
        last_n      = last;
        burst_cnt_n = burst_cnt;
        gnt_n       = '0;
        owner_oh    = '0;
        owner_oh[owner] = 1'b1;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    owner_n     = pick;
                    gnt_n[pick] = 1'b1;
                    burst_cnt_n = '0;
                    state_n     = GRANT;
                end
            end
            GRANT: begin
                gnt_n       = owner_oh;
                burst_cnt_n = burst_cnt + 1'b1;
                if (!req[owner]) begin
                    gnt_n   = '0;
                    state_n = RELEASE;
                end else if (burst_cnt == BURST_LAST) begin
                    if ((req & ~owner_oh) != '0) begin
                        gnt_n   = '0;
                        state_n = RELEASE;
                    end else begin
                        burst_cnt_n = '0;
                    end
                end
            end
            RELEASE: begin
                last_n  = owner;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Zero-latency port mux: only the owner's write reaches memory, and only in GRANT
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == GRANT) begin
            mem_we    = we_i[owner] & req[owner];
            mem_addr  = addr_i[int'(owner)*ADDR_W +: ADDR_W];
            mem_wdata = data_i[int'(owner)*DATA_W +: DATA_W];
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: a constant vector table for the basic grant
// sequence, hand-written multi-cycle corner cases, and a randomized run
// against a tenure-level reference model.
module tb_fb_write_arbiter;

    localparam int N  = 3;
    localparam int AW = 11;
    localparam int DW = 24;
    localparam int MB = 16;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    we_i;
    logic [N*AW-1:0] addr_i;
    logic [N*DW-1:0] data_i;
    logic [N-1:0]    gnt;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            busy;

    int vectors;
    int miscompares;

    // Reference model state: who holds the port, turnaround flag, rotation pointer
    int m_owner;
    int m_last;
    int m_prev;
    int m_held;
    bit m_dead;

    typedef struct {
        logic          rst;
        logic [N-1:0]  req;
        logic [N-1:0]  we;
        logic [N-1:0]  gnt;
        logic          mwe;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          busy;
    } vec_t;

    vec_t vec[20];

    fb_write_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .gnt       (gnt),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy)
    );

    // Free-running clock; the DUT acts on the falling edge
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    task automatic model_reset();
        m_owner = -1;
        m_dead  = 1'b0;
        m_last  = N - 1;
        m_prev  = 0;
        m_held  = 0;
    endtask

    // Advance the model across one falling edge using the currently driven inputs
    task automatic model_advance();
        logic [N-1:0] others;
        bit found;
        if (rst) begin
            model_reset();
        end else if (m_dead) begin
            m_dead = 1'b0;
            m_last = m_prev;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int off = 1; off <= N; off++) begin
                if (!found && req[(m_last + off) % N]) begin
                    found   = 1'b1;
                    m_owner = (m_last + off) % N;
                    m_held  = 0;
                end
            end
        end else begin
            m_held++;
            others = req;
            others[m_owner] = 1'b0;
            if (!req[m_owner] || (m_held == MB && others != '0)) begin
                m_prev  = m_owner;
                m_owner = -1;
                m_dead  = 1'b1;
            end else if (m_held == MB) begin
                m_held = 0;
            end
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic [N-1:0] rq, input logic [N-1:0] w);
        rst  = r;
        req  = rq;
        we_i = w;
    endtask

    task automatic randomize_bus();
        for (int k = 0; k < N; k++) begin
            addr_i[k*AW +: AW] = AW'($urandom);
            data_i[k*DW +: DW] = DW'($urandom);
        end
    endtask

    task automatic report(input string name, input logic [N-1:0] g, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d, input logic b);
        vectors++;
        if (gnt !== g || mem_we !== w || mem_addr !== a || mem_wdata !== d || busy !== b) begin
            miscompares++;
            $display("[TB] FAIL %s: got gnt=%b we=%b addr=%h data=%h busy=%b, want gnt=%b we=%b addr=%h data=%h busy=%b",
                     name, gnt, mem_we, mem_addr, mem_wdata, busy, g, w, a, d, b);
        end
    endtask

    // Compare the DUT against the model for this cycle, then step the model
    task automatic check_output(input string name);
        logic [N-1:0]  g;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        #1;
        g = '0; w = 1'b0; a = '0; d = '0;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            w = we_i[m_owner] & req[m_owner];
            a = addr_i[m_owner*AW +: AW];
            d = data_i[m_owner*DW +: DW];
        end
        report(name, g, w, a, d, (m_owner >= 0) || m_dead);
        model_advance();
    endtask

    task automatic check_val(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        apply_stimulus(1'b1, '0, '0);
        @(posedge clk);
        model_reset();
    endtask

    initial begin
        int run0, first_b, last_c, cnt, we_cnt;
        bit regrant;
        vectors     = 0;
        miscompares = 0;
        addr_i = '0;
        data_i = '0;
        apply_stimulus(1'b1, '0, '0);
        model_reset();

        // Reset state
        do_reset();
        #1;
        report("reset_state", '0, 1'b0, '0, '0, 1'b0);

        // Fixed bus values so the mux selection is visible in the table
        addr_i = {11'h3C1, 11'h005, 11'h7AA};
        data_i = {24'hABCDEF, 24'hFFFFFF, 24'h123456};

        vec[0]  = '{1'b0, 3'b010, 3'b010, 3'b000, 1'b0, 11'h000, 24'h000000, 1'b0};
        vec[1]  = '{1'b0, 3'b010, 3'b010, 3'b010, 1'b1, 11'h005, 24'hFFFFFF, 1'b1};
        vec[2]  = '{1'b0, 3'b000, 3'b000, 3'b010, 1'b0, 11'h005, 24'hFFFFFF, 1'b1};
        vec[3]  = '{1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 11'h000, 24'h000000, 1'b1};
        vec[4]  = '{1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 11'h000, 24'h000000, 1'b0};
        vec[5]  = '{1'b1, 3'b111, 3'b000, 3'b000, 1'b0, 11'h000, 24'h000000, 1'b0};
        vec[6]  = '{1'b0, 3'b111, 3'b000, 3'b000, 1'b0, 11'h000, 24'h000000, 1'b0};
        vec[7]  = '{1'b0, 3'b110, 3'b110, 3'b001, 1'b0, 11'h7AA, 24'h123456, 1'b1};
        vec[8]  = '{1'b0, 3'b110, 3'b110, 3'b000, 1'b0, 11'h000, 24'h000000, 1'b1};
        vec[9]  = '{1'b0, 3'b110, 3'b000, 3'b000, 1'b0, 11'h000, 24'h000000, 1'b0};
        vec[10] = '{1'b0, 3'b101, 3'b111, 3'b010, 1'b0, 11'h005, 24'hFFFFFF, 1'b1};
        vec[11] = '{1'b0, 3'b101, 3'b000, 3'b000, 1'b0, 11'h000, 24'h000000, 1'b1};
        vec[12] = '{1'b0, 3'b101, 3'b000, 3'b000, 1'b0, 11'h000, 24'h000000, 1'b0};
        vec[13] = '{1'b0, 3'b001, 3'b100, 3'b100, 1'b0, 11'h3C1, 24'hABCDEF, 1'b1};
        vec[14] = '{1'b0, 3'b001, 3'b000, 3'b000, 1'b0, 11'h000, 24'h000000, 1'b1};
        vec[15] = '{1'b0, 3'b001, 3'b000, 3'b000, 1'b0, 11'h000, 24'h000000, 1'b0};
        vec[16] = '{1'b0, 3'b001, 3'b111, 3'b001, 1'b1, 11'h7AA, 24'h123456, 1'b1};
        vec[17] = '{1'b0, 3'b000, 3'b000, 3'b001, 1'b0, 11'h7AA, 24'h123456, 1'b1};
        vec[18] = '{1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 11'h000, 24'h000000, 1'b1};
        vec[19] = '{1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 11'h000, 24'h000000, 1'b0};

        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            apply_stimulus(vec[i].rst, vec[i].req, vec[i].we);
            #1;
            report($sformatf("table[%0d]", i), vec[i].gnt, vec[i].mwe, vec[i].addr, vec[i].data, vec[i].busy);
            model_advance();
        end

        // Long clear preempted by the brush after exactly MB granted cycles
        do_reset();
        run0 = 0; first_b = -1; last_c = -1; regrant = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            randomize_bus();
            apply_stimulus(1'b0, {1'b0, 1'(c >= 3 && c < 26), 1'(c < 40)}, 3'b111);
            check_output("clear_vs_brush");
            if (gnt == 3'b001 && first_b < 0) begin
                run0++;
                last_c = c;
            end
            if (gnt == 3'b010 && first_b < 0) first_b = c;
            if (gnt == 3'b001 && first_b >= 0) regrant = 1'b1;
        end
        check_val("clear_burst_len", run0, MB);
        check_val("brush_gap", first_b - last_c, 3);
        check_val("clear_regrant", int'(regrant), 1);

        // Clear alone keeps the port continuously across burst wraps
        do_reset();
        cnt = 0;
        for (int c = 0; c < 42; c++) begin
            @(posedge clk);
            randomize_bus();
            apply_stimulus(1'b0, 3'b001, 3'b001);
            check_output("clear_alone");
            if (gnt == 3'b001) cnt++;
        end
        check_val("clear_alone_len", cnt, 41);

        // Idle cursor holder never writes and is still preempted
        do_reset();
        cnt = 0; we_cnt = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            randomize_bus();
            apply_stimulus(1'b0, {1'b1, 1'b0, 1'(c >= 1)}, 3'b000);
            check_output("idle_holder");
            if (gnt == 3'b100) cnt++;
            if (mem_we) we_cnt++;
        end
        check_val("idle_holder_len", cnt, MB);
        check_val("idle_holder_writes", we_cnt, 0);

        // Reset in the middle of a clear burst
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            randomize_bus();
            apply_stimulus(1'(c == 5), (c >= 6) ? 3'b111 : 3'b001, 3'b111);
            check_output("reset_mid_burst");
            if (c == 6) begin
                check_val("rst_gnt", int'(gnt), 0);
                check_val("rst_busy", int'(busy), 0);
            end
            if (c == 7) check_val("rst_first_owner", int'(gnt), 1);
        end

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            logic [N-1:0] r;
            @(posedge clk);
            randomize_bus();
            r = req;
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(5) == 0) r[k] = ~r[k];
            end
            apply_stimulus(1'($urandom_range(149) == 0), r, N'($urandom));
            check_output("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
